scoreboarded_register_file: RTL and testbench
=============================================

# scoreboarded_register_file

Parametrised successor to the single-issue GPR file for the pipelined QuantiumV core. It provides N configurable combinational read ports with write-to-read bypass and one write port. It adds a per-register busy scoreboard for in-flight writebacks and a post-reset sequential clear engine that zeroes every GPR. It sits between decode/issue (reads, scoreboard set) and writeback (data, scoreboard clear).

## Interface
- num_regs, default `REG_FILE_SIZE` (32): architectural GPR count including hardwired r0.
- l2_num_regs, default `L2_REG_FILE_SIZE` (5): ceil(log2(num_regs)).
- num_read_ports, default 2: number of independent read ports (1..8).
- reset_vector, default 0: value loaded into the PC on reset.
- Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_read_sel  in  num_read_ports*l2_num_regs  packed read selects; port p uses bits [p*l2_num_regs +: l2_num_regs].
- o_read_data  out  num_read_ports*`WORD_SIZE  packed read data, same packing as i_read_sel.
- o_read_busy  out  num_read_ports  port p's register has a pending write not satisfied by bypass.
- i_issue  in  1  mark i_issue_sel busy (instruction with destination issued).
- i_issue_sel  in  l2_num_regs  destination being issued.
- i_load_gpr  in  1  writeback strobe.
- i_load_gpr_sel  in  l2_num_regs  writeback destination.
- i_load_gpr_data  in  `WORD_SIZE  writeback data.
- i_load_pc  in  1  load PC.
- i_load_pc_data  in  `WORD_SIZE  new PC.
- o_program_counter  out  `WORD_SIZE  current PC.
- o_link_register  out  `WORD_SIZE  r1 contents.
- o_stack_pointer  out  `WORD_SIZE  r2 contents.
- o_ready  out  1  clear complete; the file accepts issue and writeback.

## Operation
- Storage: num_regs-1 words (r1..r(num_regs-1)); r0 is not stored and reads as 0.
- FSM states: CLEAR and READY.
- Reset (async): state CLEAR, clear counter = 1, all busy bits = 0, PC = reset_vector, o_ready = 0.
- CLEAR: each edge writes 0 to r[counter] and increments the counter. After writing r(num_regs-1), the FSM moves to READY.
  - i_issue, i_load_gpr and i_load_pc are ignored.
  - o_read_data, o_link_register and o_stack_pointer are forced to 0.
  - o_read_busy is 0.
- READY, read port p:
  - sel = 0 or sel ≥ num_regs: data 0, busy 0.
  - Else if i_load_gpr and i_load_gpr_sel == sel: data = i_load_gpr_data (bypass), busy 0.
  - Else: data = r[sel], busy = busy[sel].
- READY, writeback: when i_load_gpr is high and 0 < sel < num_regs, write the data and clear busy[sel].
- READY, issue: when i_issue is high and 0 < sel < num_regs, set busy[sel].
- Same edge, issue and writeback to the same register: the data is written and busy ends at 1 (issue wins). Different registers: both take effect.
- Issue of a register that is already busy leaves it busy. A single bit per register; WAW ordering is the pipeline's responsibility.
- PC: loaded on any READY edge with i_load_pc; otherwise held. Independent of GPR traffic.
- o_link_register and o_stack_pointer carry stored r1/r2 (no bypass). o_stack_pointer = 0 if num_regs ≤ 2.

## Timing
- Reads: zero-latency combinational, including bypass; no read-port conflicts.
- Writes: visible via stored state from the edge after the strobe.
- Clear duration: exactly num_regs-1 rising edges after reset deassertion. o_ready goes high after the (num_regs-1)th edge (31 edges at default).
- Busy: set/clear visible the cycle after the issue/writeback edge.
- Reset asserted mid-operation or mid-clear: immediate return to the reset state, then a full clear restarts from r1.

## Test plan
- Reset, release, count edges: o_ready = 0 for 31 edges, 1 after the 31st. PC = reset_vector; all reads return 0 throughout.
- After ready, write r5 = 0xDEADBEEF, then read it on all ports: next cycle returns 0xDEADBEEF. Reading r5 in the same cycle as the write also returns 0xDEADBEEF via bypass. Writing r0 = 0x1234 reads back 0.
- Issue r7, then read: o_read_busy = 1 the following cycle. Writeback r7 = 0x55: busy drops and data = 0x55 in that cycle via bypass; stored the next cycle.
- Same edge issue r9 and writeback r9 = 0xA5: data reads 0xA5, busy = 1. Issue r0: busy stays 0.
- Assert i_rst during cycle 10 of the clear and during READY with r3 busy: outputs return to reset values immediately, a full 31-edge clear follows, and r3 is no longer busy.

Source files
------------

// File: rtl/scoreboarded_register_file.sv
// GPR file with N combinational read ports, writeback bypass, a per-register
// busy scoreboard and a post-reset engine that zeroes r1..r(num_regs-1).
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef REG_FILE_SIZE
`define REG_FILE_SIZE 32
`endif
`ifndef L2_REG_FILE_SIZE
`define L2_REG_FILE_SIZE 5
`endif

module scoreboarded_register_file #(
  parameter int                    num_regs       = `REG_FILE_SIZE,
  parameter int                    l2_num_regs    = `L2_REG_FILE_SIZE,
  parameter int                    num_read_ports = 2,
  parameter logic [`WORD_SIZE-1:0] reset_vector   = '0
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst,
  input  logic [num_read_ports*l2_num_regs-1:0]  i_read_sel,
  output logic [num_read_ports*`WORD_SIZE-1:0]   o_read_data,
  output logic [num_read_ports-1:0]              o_read_busy,
  input  logic                                   i_issue,
  input  logic [l2_num_regs-1:0]                 i_issue_sel,
  input  logic                                   i_load_gpr,
  input  logic [l2_num_regs-1:0]                 i_load_gpr_sel,
  input  logic [`WORD_SIZE-1:0]                  i_load_gpr_data,
  input  logic                                   i_load_pc,
  input  logic [`WORD_SIZE-1:0]                  i_load_pc_data,
  output logic [`WORD_SIZE-1:0]                  o_program_counter,
  output logic [`WORD_SIZE-1:0]                  o_link_register,
  output logic [`WORD_SIZE-1:0]                  o_stack_pointer,
  output logic                                   o_ready
);

  localparam int DATA_W = `WORD_SIZE;
  localparam logic [l2_num_regs-1:0] CNT_FIRST = l2_num_regs'(1);
  localparam logic [l2_num_regs-1:0] CNT_LAST  = l2_num_regs'(num_regs - 1);

  typedef enum logic {CLEAR, READY} state_e;

  state_e                  state_q, state_d;
  logic [l2_num_regs-1:0]  clr_cnt_q;
  logic [DATA_W-1:0]       regs_q [1:num_regs-1];
  logic [num_regs-1:0]     busy_q, busy_d;
  logic [DATA_W-1:0]       pc_q;
  logic                    clearing, ready;
  logic                    wb_ok, iss_ok;

  // r0 is hardwired and selects past the top of the file address nothing.
  function automatic logic sel_ok(input logic [l2_num_regs-1:0] s);
    return (s != '0) && (int'(s) < num_regs);
  endfunction

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= CLEAR;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR:   if (clr_cnt_q == CNT_LAST) state_d = READY;
      READY:   state_d = READY;
      default: state_d = CLEAR;
    endcase
  end

  always_comb begin
    clearing = (state_q == CLEAR);
    ready    = (state_q == READY);
  end

  assign o_ready = ready;
  assign wb_ok   = ready && i_load_gpr && sel_ok(i_load_gpr_sel);
  assign iss_ok  = ready && i_issue && sel_ok(i_issue_sel);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)         clr_cnt_q <= CNT_FIRST;
    else if (clearing) clr_cnt_q <= clr_cnt_q + 1'b1;
  end

  // Data storage carries no reset; the clear engine zeroes it instead.
  always_ff @(posedge i_clk) begin
    if (clearing)   regs_q[clr_cnt_q]      <= '0;
    else if (wb_ok) regs_q[i_load_gpr_sel] <= i_load_gpr_data;
  end

  // Issue is applied after writeback so a same-edge pair leaves the bit set.
  always_comb begin
    busy_d = busy_q;
    if (wb_ok)  busy_d[i_load_gpr_sel] = 1'b0;
    if (iss_ok) busy_d[i_issue_sel]    = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                  pc_q <= reset_vector;
    else if (ready && i_load_pc) pc_q <= i_load_pc_data;
  end

  assign o_program_counter = pc_q;

  for (genvar p = 0; p < num_read_ports; p++) begin : g_rd
    logic [l2_num_regs-1:0] sel;
    logic [DATA_W-1:0]      rd_data;
    logic                   rd_busy;

    assign sel = i_read_sel[p*l2_num_regs +: l2_num_regs];

    always_comb begin
      rd_data = '0;
      rd_busy = 1'b0;
      if (ready && sel_ok(sel)) begin
        if (i_load_gpr && (i_load_gpr_sel == sel)) begin
          rd_data = i_load_gpr_data;
        end else begin
          rd_data = regs_q[sel];
          rd_busy = busy_q[sel];
        end
      end
    end

    assign o_read_data[p*DATA_W +: DATA_W] = rd_data;
    assign o_read_busy[p]                  = rd_busy;
  end

  assign o_link_register = ready ? regs_q[1] : '0;

  if (num_regs > 2) begin : g_sp
    assign o_stack_pointer = ready ? regs_q[2] : '0;
  end else begin : g_no_sp
    assign o_stack_pointer = '0;
  end

endmodule

// File: tb/tb_scoreboarded_register_file.sv
// Randomized and directed bench for scoreboarded_register_file against a
// behavioural model of the register file, scoreboard and clear sequence.
module tb_scoreboarded_register_file;

  localparam int          NR = 32;
  localparam int          L2 = 5;
  localparam int          NP = 2;
  localparam logic [31:0] RV = 32'h0000_1000;

  logic               i_clk = 1'b0;
  logic               i_rst;
  logic [NP*L2-1:0]   i_read_sel;
  logic [NP*32-1:0]   o_read_data;
  logic [NP-1:0]      o_read_busy;
  logic               i_issue;
  logic [L2-1:0]      i_issue_sel;
  logic               i_load_gpr;
  logic [L2-1:0]      i_load_gpr_sel;
  logic [31:0]        i_load_gpr_data;
  logic               i_load_pc;
  logic [31:0]        i_load_pc_data;
  logic [31:0]        o_program_counter;
  logic [31:0]        o_link_register;
  logic [31:0]        o_stack_pointer;
  logic               o_ready;

  scoreboarded_register_file #(
    .num_regs(NR), .l2_num_regs(L2), .num_read_ports(NP), .reset_vector(RV)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_read_sel(i_read_sel), .o_read_data(o_read_data), .o_read_busy(o_read_busy),
    .i_issue(i_issue), .i_issue_sel(i_issue_sel),
    .i_load_gpr(i_load_gpr), .i_load_gpr_sel(i_load_gpr_sel), .i_load_gpr_data(i_load_gpr_data),
    .i_load_pc(i_load_pc), .i_load_pc_data(i_load_pc_data),
    .o_program_counter(o_program_counter), .o_link_register(o_link_register),
    .o_stack_pointer(o_stack_pointer), .o_ready(o_ready)
  );

  always #5 i_clk = ~i_clk;

  // Reference model: architectural contents, busy flags, PC, edges since reset.
  logic [31:0] m_regs [NR];
  bit          m_busy [NR];
  logic [31:0] m_pc;
  int          m_edges;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] rd(input int p);
    return o_read_data[p*32 +: 32];
  endfunction

  function automatic bit m_ready();
    return m_edges >= NR - 1;
  endfunction

  task automatic set_rd(input int p, input int sel);
    i_read_sel[p*L2 +: L2] = L2'(sel);
  endtask

  task automatic idle();
    i_issue = 0; i_issue_sel = '0;
    i_load_gpr = 0; i_load_gpr_sel = '0; i_load_gpr_data = '0;
    i_load_pc = 0; i_load_pc_data = '0;
    for (int p = 0; p < NP; p++) set_rd(p, $urandom_range(0, NR - 1));
  endtask

  function automatic int rsel();
    return ($urandom_range(0, 3) == 0) ? $urandom_range(0, NR - 1) : $urandom_range(0, 7);
  endfunction

  task automatic rand_inputs();
    i_issue         = ($urandom_range(0, 3) == 0);
    i_issue_sel     = L2'(rsel());
    i_load_gpr      = ($urandom_range(0, 2) == 0);
    i_load_gpr_sel  = L2'(rsel());
    i_load_gpr_data = $urandom;
    i_load_pc       = ($urandom_range(0, 7) == 0);
    i_load_pc_data  = $urandom;
    for (int p = 0; p < NP; p++)
      set_rd(p, ($urandom_range(0, 2) == 0) ? int'(i_load_gpr_sel) : rsel());
  endtask

  task automatic check_outputs(input string tag);
    logic [L2-1:0] s;
    logic [31:0]   ed;
    logic          eb;
    bit            rdy;
    rdy = m_ready();
    chk({tag, ".ready"}, 32'(o_ready), 32'(rdy));
    chk({tag, ".pc"}, o_program_counter, m_pc);
    chk({tag, ".lr"}, o_link_register, rdy ? m_regs[1] : 32'h0);
    chk({tag, ".sp"}, o_stack_pointer, rdy ? m_regs[2] : 32'h0);
    for (int p = 0; p < NP; p++) begin
      s = i_read_sel[p*L2 +: L2];
      if (!rdy || s == 0) begin
        ed = '0; eb = 1'b0;
      end else if (i_load_gpr && i_load_gpr_sel == s) begin
        ed = i_load_gpr_data; eb = 1'b0;
      end else begin
        ed = m_regs[s]; eb = m_busy[s];
      end
      chk($sformatf("%s.rd%0d.data", tag, p), rd(p), ed);
      chk($sformatf("%s.rd%0d.busy", tag, p), 32'(o_read_busy[p]), 32'(eb));
    end
  endtask

  task automatic model_edge();
    if (!m_ready()) begin
      m_edges++;
      if (m_ready()) for (int r = 0; r < NR; r++) m_regs[r] = '0;
    end else begin
      if (i_load_gpr && i_load_gpr_sel != 0) begin
        m_regs[i_load_gpr_sel] = i_load_gpr_data;
        m_busy[i_load_gpr_sel] = 0;
      end
      if (i_issue && i_issue_sel != 0) m_busy[i_issue_sel] = 1;
      if (i_load_pc) m_pc = i_load_pc_data;
    end
  endtask

  // Called at a falling edge with inputs already driven.
  task automatic cycle(input string tag);
    #1 check_outputs(tag);
    model_edge();
    @(negedge i_clk);
  endtask

  task automatic do_reset(input string tag);
    i_rst = 1'b1;
    m_edges = 0;
    m_pc = RV;
    for (int r = 0; r < NR; r++) m_busy[r] = 0;
    #1;
    chk({tag, ".rst_ready"}, 32'(o_ready), 32'h0);
    chk({tag, ".rst_pc"}, o_program_counter, RV);
    check_outputs({tag, ".rst"});
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  task automatic clear_phase(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      rand_inputs();
      #1;
      chk({tag, ".clr_ready"}, 32'(o_ready), 32'h0);
      chk({tag, ".clr_rd0"}, rd(0), 32'h0);
      cycle(tag);
    end
    if (n == NR - 1) begin
      idle();
      #1 chk({tag, ".clr_done"}, 32'(o_ready), 32'h1);
    end
  endtask

  initial begin
    i_rst = 1'b1;
    i_read_sel = '0;
    idle();
    @(negedge i_clk);
    do_reset("init");
    clear_phase("init", NR - 1);

    idle(); i_load_gpr = 1; i_load_gpr_sel = 5; i_load_gpr_data = 32'hDEADBEEF;
    set_rd(0, 5); set_rd(1, 5);
    #1 chk("r5_bypass_p0", rd(0), 32'hDEADBEEF); chk("r5_bypass_p1", rd(1), 32'hDEADBEEF);
    cycle("wr_r5");
    idle(); set_rd(0, 5); set_rd(1, 5);
    #1 chk("r5_stored_p0", rd(0), 32'hDEADBEEF); chk("r5_stored_p1", rd(1), 32'hDEADBEEF);
    cycle("rd_r5");

    idle(); i_load_gpr = 1; i_load_gpr_sel = 0; i_load_gpr_data = 32'h1234; set_rd(0, 0);
    #1 chk("r0_bypass", rd(0), 32'h0);
    cycle("wr_r0");
    idle(); set_rd(0, 0);
    #1 chk("r0_stored", rd(0), 32'h0);
    cycle("rd_r0");

    idle(); i_issue = 1; i_issue_sel = 7; cycle("iss_r7");
    idle(); set_rd(0, 7);
    #1 chk("r7_busy", 32'(o_read_busy[0]), 32'h1);
    cycle("busy_r7");
    idle(); i_load_gpr = 1; i_load_gpr_sel = 7; i_load_gpr_data = 32'h55; set_rd(0, 7);
    #1 chk("r7_wb_busy", 32'(o_read_busy[0]), 32'h0); chk("r7_wb_data", rd(0), 32'h55);
    cycle("wb_r7");
    idle(); set_rd(1, 7);
    #1 chk("r7_stored", rd(1), 32'h55); chk("r7_idle_busy", 32'(o_read_busy[1]), 32'h0);
    cycle("rd_r7");

    idle(); i_issue = 1; i_issue_sel = 9; i_load_gpr = 1; i_load_gpr_sel = 9;
    i_load_gpr_data = 32'hA5; cycle("iss_wb_r9");
    idle(); set_rd(0, 9);
    #1 chk("r9_data", rd(0), 32'hA5); chk("r9_busy", 32'(o_read_busy[0]), 32'h1);
    cycle("rd_r9");
    idle(); i_issue = 1; i_issue_sel = 0; cycle("iss_r0");
    idle(); set_rd(0, 0);
    #1 chk("r0_busy", 32'(o_read_busy[0]), 32'h0);
    cycle("rd_r0b");

    idle(); i_load_pc = 1; i_load_pc_data = 32'h0000_0400; cycle("ld_pc");
    idle();
    #1 chk("pc_loaded", o_program_counter, 32'h0000_0400);
    cycle("pc_hold");

    do_reset("midclr_a");
    clear_phase("midclr_a", 10);
    do_reset("midclr_b");
    clear_phase("midclr_b", NR - 1);

    idle(); i_issue = 1; i_issue_sel = 3; cycle("iss_r3");
    idle(); set_rd(0, 3);
    #1 chk("r3_busy", 32'(o_read_busy[0]), 32'h1);
    cycle("rd_r3");
    set_rd(0, 3);
    do_reset("rdy_rst");
    clear_phase("rdy_rst", NR - 1);
    idle(); set_rd(0, 3);
    #1 chk("r3_not_busy", 32'(o_read_busy[0]), 32'h0); chk("r3_cleared", rd(0), 32'h0);
    cycle("rd_r3b");

    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      cycle("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
